// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with the
// trial subtraction done by a parallel-prefix adder as x + ~y + 1.

module prefix_adder #(
    parameter int WIDTH  = 8,
    parameter int LEVELS = 3
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    logic [LEVELS:0][WIDTH-1:0] g_s;
    logic [LEVELS:0][WIDTH-1:0] p_s;
    logic [WIDTH:0]             c_s;

    // Kogge-Stone generate/propagate tree, then fold carry_in into every carry.
    always_comb begin
        int span;
        int j;
        g_s    = '0;
        p_s    = '0;
        c_s    = '0;
        span   = 32'sd1;
        j      = 32'sd0;
        g_s[0] = x & y;
        p_s[0] = x ^ y;
        for (int l = 0; l < LEVELS; l++) begin
            span = 32'sd1 << l;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= span) begin
                    j = i - span;
                    g_s[l+1][i] = g_s[l][i] | (p_s[l][i] & g_s[l][j]);
                    p_s[l+1][i] = p_s[l][i] & p_s[l][j];
                end else begin
                    g_s[l+1][i] = g_s[l][i];
                    p_s[l+1][i] = p_s[l][i];
                end
            end
        end
        c_s[0] = carry_in;
        for (int i = 0; i < WIDTH; i++) begin
            c_s[i+1] = g_s[LEVELS][i] | (p_s[LEVELS][i] & carry_in);
        end
    end

    assign sum       = p_s[0] ^ c_s[WIDTH-1:0];
    assign carry_out = c_s[WIDTH];
endmodule

module restoring_divider #(
    parameter int WIDTH  = 8,
    parameter int LEVELS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic [WIDTH:0]   s_s;
    logic [WIDTH-1:0] diff_s;
    logic             cout_s;
    logic             take_s;
    logic [WIDTH-1:0] next_p_s;
    logic [WIDTH-1:0] next_q_s;

    // Shift the next dividend bit into the partial remainder and trial-subtract D.
    assign s_s = {p_r, q_r[WIDTH-1]};

    prefix_adder #(.WIDTH(WIDTH), .LEVELS(LEVELS)) u_sub (
        .x         (s_s[WIDTH-1:0]),
        .y         (~d_r),
        .carry_in  (1'b1),
        .sum       (diff_s),
        .carry_out (cout_s)
    );

    // A set top bit of s means s >= 2^WIDTH > D, so the subtraction always fits.
    assign take_s   = s_s[WIDTH] | cout_s;
    assign next_p_s = take_s ? diff_s : s_s[WIDTH-1:0];
    assign next_q_s = {q_r[WIDTH-2:0], take_s};

    // Control FSM with datapath registers and registered result outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= IDLE;
            p_r         <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            count_r     <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        if (divisor != {WIDTH{1'b0}}) begin
                            d_r     <= divisor;
                            p_r     <= {WIDTH{1'b0}};
                            q_r     <= dividend;
                            count_r <= {CW{1'b0}};
                            busy_r  <= 1'b1;
                            state_r <= RUN;
                        end else begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                            done_r      <= 1'b1;
                            state_r     <= DONE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    p_r     <= next_p_s;
                    q_r     <= next_q_s;
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (count_r == LAST_STEP) begin
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        quotient_r  <= next_q_s;
                        remainder_r <= next_p_s;
                        dbz_r       <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases from the
// datasheet examples plus a random sweep against plain integer division.

module tb_restoring_divider;
    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_cmp;
    int n_fail;

    restoring_divider #(.WIDTH(8), .LEVELS(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
        check({tag, ".q"}, {24'd0, quotient}, 32'd0);
        check({tag, ".r"}, {24'd0, remainder}, 32'd0);
        check({tag, ".dbz"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    // Called at a negedge; leaves the bench at the negedge after the done cycle.
    // glitch_cyc: cycle in which a stray start (1/1) is pulsed; rst_cyc: cycle
    // in which reset is asserted (0 = never).
    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input string tag,
                          input int glitch_cyc, input int rst_cyc);
        logic [7:0] eq;
        logic [7:0] er;
        logic       edbz;
        int         exp_lat;
        int         lat;
        int         busy_cnt;
        bit         aborted;
        if (b == 8'd0) begin
            eq = 8'd255; er = a; edbz = 1'b1; exp_lat = 1;
        end else begin
            eq = a / b; er = a % b; edbz = 1'b0; exp_lat = 9;
        end
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clock);
        start = 1'b0;
        dividend = 8'($urandom); divisor = 8'($urandom);
        lat = 1; busy_cnt = 0; aborted = 1'b0;
        while (lat < 30) begin
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cnt++;
            if (lat == rst_cyc) begin
                reset = 1'b0;
                @(negedge clock);
                reset = 1'b1;
                check_idle_zero({tag, ".rst"});
                @(negedge clock);
                check({tag, ".rst.nodone"}, {31'd0, done}, 32'd0);
                aborted = 1'b1;
                break;
            end
            start = (lat == glitch_cyc);
            if (start) begin
                dividend = 8'd1; divisor = 8'd1;
            end
            @(negedge clock);
            start = 1'b0;
            lat++;
        end
        if (!aborted) begin
            check({tag, ".lat"}, lat, exp_lat);
            check({tag, ".busycnt"}, busy_cnt, (b == 8'd0) ? 0 : 8);
            check({tag, ".q"}, {24'd0, quotient}, {24'd0, eq});
            check({tag, ".r"}, {24'd0, remainder}, {24'd0, er});
            check({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
            if (b != 8'd0) begin
                check({tag, ".inv"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                check({tag, ".rltd"}, {31'd0, remainder < b}, 32'd1);
            end
            @(negedge clock);
            check({tag, ".done1cyc"}, {31'd0, done}, 32'd0);
            check({tag, ".idle"}, {31'd0, busy}, 32'd0);
            check({tag, ".holdq"}, {24'd0, quotient}, {24'd0, eq});
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (3) @(negedge clock);
        check_idle_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        do_div(8'd200, 8'd7, "200/7", 0, 0);
        do_div(8'd255, 8'd1, "255/1", 0, 0);
        do_div(8'd5, 8'd9, "5/9", 0, 0);
        do_div(8'd0, 8'd3, "0/3", 0, 0);
        do_div(8'd77, 8'd0, "77/0", 0, 0);
        do_div(8'd9, 8'd3, "9/3", 0, 0);
        do_div(8'd100, 8'd10, "100/10glitch", 3, 0);
        @(negedge clock);
        check("noqueue", {31'd0, busy}, 32'd0);
        do_div(8'd250, 8'd3, "250/3rst", 0, 4);
        do_div(8'd250, 8'd3, "250/3", 0, 0);
        do_div(8'd255, 8'd255, "255/255", 0, 0);
        do_div(8'd254, 8'd255, "254/255", 0, 0);

        // Back-to-back random divisions, each started in the cycle after done.
        for (int n = 0; n < 300; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = (n % 17 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (n % 3 == 0) b = 8'($urandom_range(1, 15));
            do_div(a, b, "rand", 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
